key_checker: RTL and testbench

KEY_CHECKER -- requirements
Module: key_checker

---
 rtl/alarm_pkg.sv | 21 ++
 rtl/sync_edge.sv | 27 ++
 rtl/key_checker.sv | 157 +++++++++++++++
 tb/tb_key_checker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared alarm definitions: KEY_STATUS encodings, key_checker state type and the code compare helper.
`timescale 1ns/1ps
package alarm_pkg;

  localparam logic [1:0] KEY_OK    = 2'd0;
  localparam logic [1:0] KEY_ERROR = 2'd2;
  localparam logic [1:0] NO_KEY    = 2'd3;

  typedef enum logic [1:0] {
    KC_IDLE   = 2'd0,
    KC_ENTRY  = 2'd1,
    KC_REPORT = 2'd2,
    KC_LOCKED = 2'd3
  } kc_state_t;

  // Entered digits are packed first-digit-in-MSBs, the same layout as the CODE parameter.
  function automatic logic [1:0] key_result(input logic [7:0] code, input logic [7:0] entered);
    return (entered == code) ? KEY_OK : KEY_ERROR;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous level input.
// One-cycle pulse two clocks after the level rises; edges are never queued (no backpressure).
`timescale 1ns/1ps
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;

  // prev_q clears with the synchronizer so a level already high at reset release yields one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], level};
      prev_q <= sync_q[1];
    end
  end

  assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/key_checker.sv
// 4-digit keypad code checker; result registered with the 4th digit (3 clocks after KB_RECV rises), held until KEY_RST.
// Digits arriving while a result is held are dropped. Define KEY_LOCKOUT_EN for the MAX_TRIES/LOCKOUT_CYC lockout.
`timescale 1ns/1ps
module key_checker
  import alarm_pkg::*;
#(
  parameter logic [7:0] CODE          = 8'b00_01_10_11,
  parameter int         DIGIT_TIMEOUT = 1000,
  parameter int         MAX_TRIES     = 3,
  parameter int         LOCKOUT_CYC   = 5000
) (
  input  logic       SERCLK_OUT,
  input  logic       RESET_IN,
  input  logic [1:0] KB_IN,
  input  logic       KB_RECV,
  input  logic       KEY_RST,
  output logic [1:0] KEY_STATUS
);

  localparam int            TW       = $clog2(DIGIT_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(DIGIT_TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(DIGIT_TIMEOUT - 1);

  kc_state_t     state_q, state_d;
  logic [7:0]    digits_q, digits_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    status_q, status_d;
  logic          digit_pulse;

`ifdef KEY_LOCKOUT_EN
  localparam int            EW        = $clog2(MAX_TRIES + 1);
  localparam int            LW        = $clog2(LOCKOUT_CYC + 1);
  localparam logic [EW-1:0] ERR_MAX   = EW'(MAX_TRIES);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYC - 1);

  logic [EW-1:0] err_q, err_d;
  logic [LW-1:0] lock_q, lock_d;
`else
  localparam int CFG_UNUSED = MAX_TRIES + LOCKOUT_CYC;
`endif

  sync_edge u_kb_sync (
    .clk   (SERCLK_OUT),
    .rst   (RESET_IN),
    .level (KB_RECV),
    .pulse (digit_pulse)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    status_d = status_q;
`ifdef KEY_LOCKOUT_EN
    err_d    = err_q;
    lock_d   = lock_q;
`endif
    case (state_q)
      KC_IDLE: begin
        status_d = NO_KEY;
        tmr_d    = '0;
        if (digit_pulse) begin
          digits_d = {6'b000000, KB_IN};
          cnt_d    = 3'd1;
          state_d  = KC_ENTRY;
        end
      end
      KC_ENTRY: begin
        // A digit arriving on the expiry cycle still counts and restarts the timer.
        if (digit_pulse) begin
          digits_d = {digits_q[5:0], KB_IN};
          cnt_d    = cnt_q + 3'd1;
          tmr_d    = '0;
          if (cnt_q == 3'd3) begin
            state_d  = KC_REPORT;
            status_d = key_result(CODE, digits_d);
`ifdef KEY_LOCKOUT_EN
            if (status_d == KEY_OK) begin
              err_d = '0;
            end else if (err_q != ERR_MAX) begin
              err_d = err_q + 1'b1;
            end
`endif
          end
        end else if (tmr_q == TMR_LAST) begin
          state_d  = KC_IDLE;
          digits_d = '0;
          cnt_d    = '0;
          tmr_d    = '0;
        end else if (tmr_q != TMR_MAX) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      KC_REPORT: begin
        if (KEY_RST) begin
          status_d = NO_KEY;
          digits_d = '0;
          cnt_d    = '0;
`ifdef KEY_LOCKOUT_EN
          lock_d   = '0;
          state_d  = (err_q == ERR_MAX) ? KC_LOCKED : KC_IDLE;
`else
          state_d  = KC_IDLE;
`endif
        end
      end
`ifdef KEY_LOCKOUT_EN
      KC_LOCKED: begin
        status_d = NO_KEY;
        if (lock_q == LOCK_LAST) begin
          state_d = KC_IDLE;
          err_d   = '0;
          lock_d  = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d  = KC_IDLE;
        status_d = NO_KEY;
        digits_d = '0;
        cnt_d    = '0;
        tmr_d    = '0;
      end
    endcase
  end

  always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q  <= KC_IDLE;
      digits_q <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      status_q <= NO_KEY;
`ifdef KEY_LOCKOUT_EN
      err_q    <= '0;
      lock_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      status_q <= status_d;
`ifdef KEY_LOCKOUT_EN
      err_q    <= err_d;
      lock_q   <= lock_d;
`endif
    end
  end

  assign KEY_STATUS = status_q;

endmodule

// File: tb/tb_key_checker.sv
// Bench for key_checker: vector table, directed timing corners and randomized entries against a digit-queue model.
`timescale 1ns/1ps
module tb_key_checker;
  import alarm_pkg::*;

  localparam logic [7:0] CODE_DEF = 8'b00_01_10_11;
  localparam int TMO   = 1000;
  localparam int TRIES = 3;
  localparam int LOCK  = 5000;

  typedef struct packed {
    logic [7:0] code;
    logic [1:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       kb_recv;
  logic       key_rst;
  logic [1:0] kb_in;
  logic [1:0] status;

  int n_vec = 0;
  int n_bad = 0;
  int model_err = 0;
  vec_t tbl [8];

  always #5 clk = ~clk;

  key_checker #(
    .CODE(CODE_DEF), .DIGIT_TIMEOUT(TMO), .MAX_TRIES(TRIES), .LOCKOUT_CYC(LOCK)
  ) dut (
    .SERCLK_OUT(clk), .RESET_IN(rst), .KB_IN(kb_in), .KB_RECV(kb_recv),
    .KEY_RST(key_rst), .KEY_STATUS(status)
  );

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: KEY_STATUS=%0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: digits compared one by one against CODE, first digit from the top bits.
  function automatic logic [1:0] ref_result(input logic [7:0] c);
    int got [$];
    int want [$];
    bit same;
    for (int i = 0; i < 4; i++) begin
      got.push_back(int'((c >> (6 - 2 * i)) & 8'd3));
      want.push_back(int'((CODE_DEF >> (6 - 2 * i)) & 8'd3));
    end
    same = 1'b1;
    for (int i = 0; i < 4; i++) if (got[i] != want[i]) same = 1'b0;
    return same ? KEY_OK : KEY_ERROR;
  endfunction

  task automatic note_result(input logic [1:0] e);
    if (e == KEY_ERROR) model_err++;
    else if (e == KEY_OK) model_err = 0;
  endtask

  task automatic send_digit(input logic [1:0] d);
    @(negedge clk);
    kb_in = d;
    kb_recv = 1'b1;
    repeat ($urandom_range(6, 3)) @(negedge clk);
    kb_recv = 1'b0;
    repeat ($urandom_range(8, 3)) @(negedge clk);
  endtask

  task automatic enter_code(input logic [7:0] c, input logic [1:0] exp, input string name);
    for (int i = 0; i < 4; i++) begin
      send_digit(c[7 - 2 * i -: 2]);
      if (i < 3) check({name, "_partial"}, status, NO_KEY);
    end
    check({name, "_result"}, status, exp);
    note_result(exp);
  endtask

  task automatic ack(input bit wait_lock, input string name);
    @(negedge clk);
    key_rst = 1'b1;
    @(negedge clk);
    key_rst = 1'b0;
    check({name, "_ack"}, status, NO_KEY);
`ifdef KEY_LOCKOUT_EN
    if (model_err >= TRIES) begin
      model_err = 0;
      if (wait_lock) repeat (LOCK + 20) @(negedge clk);
    end
`else
    if (wait_lock) model_err = 0;
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_err = 0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    logic [1:0] e;
    int k;

    tbl[0] = '{8'b00_01_10_11, KEY_OK};
    tbl[1] = '{8'b11_01_10_11, KEY_ERROR};
    tbl[2] = '{8'b00_01_10_10, KEY_ERROR};
    tbl[3] = '{8'b00_01_11_11, KEY_ERROR};
    tbl[4] = '{8'b00_00_10_11, KEY_ERROR};
    tbl[5] = '{8'b00_00_00_00, KEY_ERROR};
    tbl[6] = '{8'b11_10_01_00, KEY_ERROR};
    tbl[7] = '{8'b00_01_10_11, KEY_OK};

    rst = 1'b1;
    kb_in = 2'd0;
    kb_recv = 1'b0;
    key_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hold", status, NO_KEY);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("after_reset", status, NO_KEY);

    for (int i = 0; i < 8; i++) begin
      enter_code(tbl[i].code, tbl[i].exp, $sformatf("tbl%0d", i));
      ack(1'b1, $sformatf("tbl%0d", i));
    end

    // Result must be visible within 4 clocks of the 4th KB_RECV rise.
    send_digit(2'd0); send_digit(2'd1); send_digit(2'd2);
    @(negedge clk);
    kb_in = 2'd3;
    kb_recv = 1'b1;
    repeat (4) @(negedge clk);
    check("ok_latency", status, KEY_OK);
    kb_recv = 1'b0;
    note_result(KEY_OK);
    ack(1'b1, "ok_latency");

    // KEY_RST outside REPORT is ignored.
    ack(1'b1, "rst_idle");
    send_digit(2'd0); send_digit(2'd1);
    @(negedge clk); key_rst = 1'b1; @(negedge clk); key_rst = 1'b0;
    check("rst_entry", status, NO_KEY);
    send_digit(2'd2); send_digit(2'd3);
    check("rst_entry_result", status, KEY_OK);
    note_result(KEY_OK);
    ack(1'b1, "rst_entry");

    // Digits during REPORT are dropped; fresh entry after acknowledge.
    enter_code(CODE_DEF, KEY_OK, "hold");
    for (int i = 0; i < 4; i++) begin
      send_digit(2'(i));
      check("hold_ignore", status, KEY_OK);
    end
    ack(1'b1, "hold");
    enter_code(CODE_DEF, KEY_OK, "hold_next");
    ack(1'b1, "hold_next");

    // Partial entry discarded after the idle timeout.
    send_digit(2'd0); send_digit(2'd1);
    repeat (TMO) @(negedge clk);
    check("tmo_partial", status, NO_KEY);
    enter_code(CODE_DEF, KEY_OK, "tmo_after");
    ack(1'b1, "tmo_after");

    // Gap of exactly DIGIT_TIMEOUT clocks between captures: digit accepted.
    send_digit(2'd0); send_digit(2'd1);
    @(negedge clk); kb_in = 2'd2; kb_recv = 1'b1;
    repeat (3) @(negedge clk); kb_recv = 1'b0;
    repeat (TMO - 3) @(negedge clk); kb_in = 2'd3; kb_recv = 1'b1;
    repeat (4) @(negedge clk); kb_recv = 1'b0;
    check("gap_exact", status, KEY_OK);
    note_result(KEY_OK);
    ack(1'b1, "gap_exact");

    // One clock longer: entry expired, late digit becomes a new first digit.
    send_digit(2'd0); send_digit(2'd1);
    @(negedge clk); kb_in = 2'd2; kb_recv = 1'b1;
    repeat (3) @(negedge clk); kb_recv = 1'b0;
    repeat (TMO - 2) @(negedge clk); kb_in = 2'd3; kb_recv = 1'b1;
    repeat (4) @(negedge clk); kb_recv = 1'b0;
    check("gap_over", status, NO_KEY);
    send_digit(2'd1); send_digit(2'd2); send_digit(2'd3);
    check("gap_over_result", status, KEY_ERROR);
    note_result(KEY_ERROR);
    ack(1'b1, "gap_over");

    // Reset mid-entry and mid-REPORT.
    send_digit(2'd0); send_digit(2'd1); send_digit(2'd2);
    pulse_reset();
    check("rst_mid_entry", status, NO_KEY);
    enter_code(CODE_DEF, KEY_OK, "rst_mid_entry_next");
    pulse_reset();
    check("rst_mid_report", status, NO_KEY);
    enter_code(CODE_DEF, KEY_OK, "rst_mid_report_next");
    ack(1'b1, "rst_mid_report_next");

    // KB_RECV already high when reset releases counts as one digit.
    @(negedge clk); kb_in = 2'd0; kb_recv = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0; model_err = 0;
    repeat (5) @(negedge clk); kb_recv = 1'b0;
    repeat (4) @(negedge clk);
    check("rel_high_one", status, NO_KEY);
    send_digit(2'd1); send_digit(2'd2); send_digit(2'd3);
    check("rel_high_result", status, KEY_OK);
    note_result(KEY_OK);
    ack(1'b1, "rel_high");

`ifdef KEY_LOCKOUT_EN
    pulse_reset();
    for (int i = 0; i < TRIES; i++) begin
      enter_code(8'b11_01_10_11, KEY_ERROR, "lk_wrong");
      ack(1'b0, "lk_wrong");
    end
    enter_code(CODE_DEF, NO_KEY, "lk_during");
    repeat (LOCK) @(negedge clk);
    enter_code(CODE_DEF, KEY_OK, "lk_after");
    ack(1'b1, "lk_after");
`endif

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(9, 0) == 0) begin
        k = $urandom_range(3, 1);
        for (int j = 0; j < k; j++) begin
          send_digit(2'($urandom));
          check("rnd_part", status, NO_KEY);
        end
        repeat (TMO + 20) @(negedge clk);
        check("rnd_part_tmo", status, NO_KEY);
      end
      c = ($urandom_range(1, 0) == 1) ? CODE_DEF : 8'($urandom);
      e = ref_result(c);
      enter_code(c, e, $sformatf("rnd%0d", t));
      if ($urandom_range(2, 0) == 0) begin
        k = $urandom_range(4, 1);
        for (int j = 0; j < k; j++) begin
          send_digit(2'($urandom));
          check("rnd_ignore", status, e);
        end
      end
      ack(1'b1, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
